phy_tx: RTL and testbench

Transmit-side physical layer: the serializer that feeds the `data_out` line consumed by `phy_rx`. It takes four 8-bit lanes with per-lane valids, packs one byte per lane into a 32-bit frame, and shifts it out serially, MSB first, one bit per `clk_32f` cycle. After reset it emits a COM preamble so the receiver can align. It then sends lane data, substituting IDLE bytes for lanes that are not valid.

---
 rtl/phy_pkg.sv | 18 +
 rtl/phy_tx_serializer.sv | 42 ++++
 rtl/phy_tx.sv | 110 +++++++++++
 tb/tb_phy_tx.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/phy_pkg.sv
// Shared PHY definitions used by both the transmit and receive sides:
// frame geometry, default control characters and the link-state encoding.
package phy_pkg;

  localparam int unsigned LANES      = 4;
  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned FRAME_BITS = LANES * BYTE_W;
  localparam int unsigned CNT_W      = $clog2(FRAME_BITS);

  localparam logic [BYTE_W-1:0] COM_DEFAULT  = 8'hBC;
  localparam logic [BYTE_W-1:0] IDLE_DEFAULT = 8'h7C;

  typedef enum logic {
    ST_SYNC   = 1'b0,
    ST_ACTIVE = 1'b1
  } phy_state_e;

endpackage

// File: rtl/phy_tx_serializer.sv
// Frame serializer: 32-bit shift register plus bit counter. The counter
// rests at the last bit position out of reset, so the first edge after
// reset release loads a frame and its MSB drives the line from that edge.
module phy_tx_serializer
  import phy_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [FRAME_BITS-1:0] word_i,
  output logic                  load_o,
  output logic                  pre_load_o,
  output logic                  data_o
);

  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [FRAME_BITS-1:0] shift_q, shift_d;

  // Load on the last bit position, otherwise shift MSB-first; counter wraps.
  always_comb begin
    load_o     = (bit_cnt_q == CNT_W'(FRAME_BITS - 1));
    pre_load_o = (bit_cnt_q == CNT_W'(FRAME_BITS - 2));
    bit_cnt_d  = bit_cnt_q + CNT_W'(1);
    shift_d    = {shift_q[FRAME_BITS-2:0], 1'b0};
    if (load_o) begin
      shift_d = word_i;
    end
  end

  // Counter and shift register; reset parks the counter just before a load.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bit_cnt_q <= CNT_W'(FRAME_BITS - 1);
      shift_q   <= '0;
    end else begin
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
    end
  end

  assign data_o = shift_q[FRAME_BITS-1];

endmodule

// File: rtl/phy_tx.sv
// Transmit PHY: sends SYNC_FRAMES all-COM frames after reset, then packs the
// four lanes (IDLE for invalid lanes) into one frame per 32 bit times.
// Optional macro PHY_TX_FRAME_MARK_EN adds the frame_start output, high
// while data_out carries the first bit of any frame.
module phy_tx
  import phy_pkg::*;
#(
  parameter int unsigned       SYNC_FRAMES = 4,
  parameter logic [BYTE_W-1:0] COM         = COM_DEFAULT,
  parameter logic [BYTE_W-1:0] IDLE        = IDLE_DEFAULT
) (
  input  logic              clk_32f,
  input  logic              reset,
  input  logic [BYTE_W-1:0] data_tx0,
  input  logic [BYTE_W-1:0] data_tx1,
  input  logic [BYTE_W-1:0] data_tx2,
  input  logic [BYTE_W-1:0] data_tx3,
  input  logic              valid_tx0,
  input  logic              valid_tx1,
  input  logic              valid_tx2,
  input  logic              valid_tx3,
  output logic              sample,
  output logic              data_out
`ifdef PHY_TX_FRAME_MARK_EN
  ,
  output logic              frame_start
`endif
);

  localparam int unsigned FC_W = $clog2(SYNC_FRAMES + 1);

  phy_state_e            state_q, state_d;
  logic [FC_W-1:0]       frame_cnt_q, frame_cnt_d;
  logic                  sample_q, sample_d;
  logic                  load, pre_load;
  logic [FRAME_BITS-1:0] word;
  logic [BYTE_W-1:0]     lane_data [LANES];
  logic [LANES-1:0]      lane_vld;

  assign lane_data = '{data_tx0, data_tx1, data_tx2, data_tx3};
  assign lane_vld  = {valid_tx3, valid_tx2, valid_tx1, valid_tx0};

  // Frame word: COM on every lane while syncing, else data or IDLE per lane.
  always_comb begin
    word = '0;
    for (int i = 0; i < LANES; i++) begin
      if (state_q == ST_SYNC) begin
        word[(LANES-1-i)*BYTE_W +: BYTE_W] = COM;
      end else if (lane_vld[i]) begin
        word[(LANES-1-i)*BYTE_W +: BYTE_W] = lane_data[i];
      end else begin
        word[(LANES-1-i)*BYTE_W +: BYTE_W] = IDLE;
      end
    end
  end

  // Next state: count COM frames at load edges, switch to ACTIVE after the
  // last one; sample flags the cycle ending in an ACTIVE load.
  always_comb begin
    state_d     = state_q;
    frame_cnt_d = frame_cnt_q;
    sample_d    = pre_load && (state_q == ST_ACTIVE);
    if (load && (state_q == ST_SYNC)) begin
      frame_cnt_d = frame_cnt_q + FC_W'(1);
      if (frame_cnt_q == FC_W'(SYNC_FRAMES - 1)) begin
        state_d = ST_ACTIVE;
      end
    end
  end

  // Control registers; ACTIVE is left only through reset.
  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_SYNC;
      frame_cnt_q <= '0;
      sample_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      frame_cnt_q <= frame_cnt_d;
      sample_q    <= sample_d;
    end
  end

  assign sample = sample_q;

  phy_tx_serializer u_ser (
    .clk_i      (clk_32f),
    .rst_ni     (reset),
    .word_i     (word),
    .load_o     (load),
    .pre_load_o (pre_load),
    .data_o     (data_out)
  );

`ifdef PHY_TX_FRAME_MARK_EN
  logic frame_start_q;

  // Marks the cycle following each load edge, i.e. bit 31 on the line.
  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      frame_start_q <= 1'b0;
    end else begin
      frame_start_q <= load;
    end
  end

  assign frame_start = frame_start_q;
`endif

endmodule

// File: tb/tb_phy_tx.sv
module tb_phy_tx;

  localparam int         SF    = 4;
  localparam logic [7:0] COMB  = 8'hBC;
  localparam logic [7:0] IDLEB = 8'h7C;

  logic       clk_32f = 1'b0;
  logic       reset   = 1'b0;
  logic [7:0] d0 = 8'hDE, d1 = 8'hAD, d2 = 8'hBE, d3 = 8'hEF;
  logic       v0 = 1'b1, v1 = 1'b1, v2 = 1'b1, v3 = 1'b1;
  logic       sample, data_out;
`ifdef PHY_TX_FRAME_MARK_EN
  logic       frame_start;
`endif

  int tests = 0;
  int fails = 0;

  // Model state: cycle index since the first edge after reset release and
  // the frame word that must be on the line during the current frame.
  bit          running = 1'b0;
  int          cyc = 0;
  logic [31:0] cur_word = '0;
  logic [31:0] rx_sh = '0;
  logic [31:0] rx_frames [16];
  int          first_sample = -1;

  always #5 clk_32f = ~clk_32f;

  phy_tx #(.SYNC_FRAMES(SF)) dut (
    .clk_32f   (clk_32f),
    .reset     (reset),
    .data_tx0  (d0),
    .data_tx1  (d1),
    .data_tx2  (d2),
    .data_tx3  (d3),
    .valid_tx0 (v0),
    .valid_tx1 (v1),
    .valid_tx2 (v2),
    .valid_tx3 (v3),
    .sample    (sample),
    .data_out  (data_out)
`ifdef PHY_TX_FRAME_MARK_EN
    ,
    .frame_start (frame_start)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cyc %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [31:0] lanes_word();
    return {v0 ? d0 : IDLEB, v1 ? d1 : IDLEB, v2 ? d2 : IDLEB, v3 ? d3 : IDLEB};
  endfunction

  // Model: frame f starts at cycle 32f; frames below SF are COM, later ones
  // are built from the inputs present at their starting edge.
  initial forever begin
    @(posedge clk_32f or negedge reset);
    if (!reset) begin
      running = 1'b0;
    end else if (!running) begin
      running  = 1'b1;
      cyc      = 0;
      cur_word = {4{COMB}};
    end else begin
      cyc = cyc + 1;
      if (cyc % 32 == 0)
        cur_word = (cyc / 32 < SF) ? {4{COMB}} : lanes_word();
    end
  end

  // Per-cycle compare against the model, plus frame capture off the line.
  initial forever begin
    @(negedge clk_32f);
    if (!reset || !running) begin
      check("idle_data_out", {31'd0, data_out}, 32'd0);
      check("idle_sample", {31'd0, sample}, 32'd0);
`ifdef PHY_TX_FRAME_MARK_EN
      check("idle_frame_start", {31'd0, frame_start}, 32'd0);
`endif
      if (!reset) first_sample = -1;
    end else begin
      check("data_out", {31'd0, data_out}, {31'd0, cur_word[31 - (cyc % 32)]});
      check("sample", {31'd0, sample},
            {31'd0, ((cyc % 32 == 31) && (cyc / 32 >= SF - 1))});
`ifdef PHY_TX_FRAME_MARK_EN
      check("frame_start", {31'd0, frame_start}, {31'd0, (cyc % 32 == 0)});
`endif
      rx_sh = {rx_sh[30:0], data_out};
      if ((cyc % 32 == 31) && (cyc / 32 < 16)) rx_frames[cyc / 32] = rx_sh;
      if (sample && first_sample < 0) first_sample = cyc;
    end
  end

  task automatic wait_cyc(input int n);
    int g = 0;
    do begin
      @(negedge clk_32f);
      g++;
    end while (!(running && cyc == n) && g < 2000);
    if (!(running && cyc == n)) begin
      fails++;
      tests++;
      $display("FAIL wait_cyc timeout waiting for cyc %0d", n);
    end
  endtask

  initial begin
    // Reset held: line and sample quiet.
    repeat (3) @(negedge clk_32f);
    #1;
    check("rst_data_out", {31'd0, data_out}, 32'd0);
    check("rst_sample", {31'd0, sample}, 32'd0);
    #1 reset = 1'b1;

    wait_cyc(0);
    check("first_bit", {31'd0, data_out}, 32'd1);

    wait_cyc(123);
    d0 = 8'hA5; d1 = 8'h3C; d2 = 8'hFF; d3 = 8'h00;
    {v0, v1, v2, v3} = 4'b1111;
    wait_cyc(155);
    d0 = 8'h11; d1 = 8'h22; d2 = 8'h81; d3 = 8'h33;
    {v0, v1, v2, v3} = 4'b0010;
    wait_cyc(187);
    d0 = 8'h12; d1 = 8'h34; d2 = 8'h56; d3 = 8'h78;
    {v0, v1, v2, v3} = 4'b1111;
    wait_cyc(202);
    d0 = 8'h55; d1 = 8'h55; d2 = 8'h55; d3 = 8'h55;

    wait_cyc(256);
    check("first_sample", first_sample, 127);
    check("frame0_com", rx_frames[0], 32'hBCBCBCBC);
    check("frame3_com", rx_frames[3], 32'hBCBCBCBC);
    check("frame4_all_valid", rx_frames[4], 32'hA53CFF00);
    check("frame5_lane2_only", rx_frames[5], 32'h7C7C817C);
    check("frame6_midframe_hold", rx_frames[6], 32'h12345678);
    check("frame7_new_data", rx_frames[7], 32'h55555555);

    // Reset in the middle of an ACTIVE frame truncates it immediately.
    wait_cyc(269);
    #2 reset = 1'b0;
    #1;
    check("midrst_data_out", {31'd0, data_out}, 32'd0);
    check("midrst_sample", {31'd0, sample}, 32'd0);
    repeat (3) @(negedge clk_32f);
    #2 reset = 1'b1;

    wait_cyc(0);
    check("rerun_first_bit", {31'd0, data_out}, 32'd1);
    wait_cyc(160);
    check("rerun_first_sample", first_sample, 127);
    check("rerun_frame0_com", rx_frames[0], 32'hBCBCBCBC);
    check("rerun_frame3_com", rx_frames[3], 32'hBCBCBCBC);
    check("rerun_frame4_data", rx_frames[4], 32'h55555555);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
